ota_bitstream_decimator: RTL and testbench
==========================================

Name:
ota_bitstream_decimator

Overview:
- Downstream consumer of the digital OTA/comparator output pin. It turns the asynchronous 1-bit comparator stream into an unsigned ones-density count over a fixed window.
- Synchronises the pin, samples it on a prescaled strobe and accumulates ones over 2^WIN_LOG2 samples.
- Presents each window result through a valid/ready handshake to the tile's digital outputs or scan logic.

Parameters:
- WIN_LOG2, 8, log2 of samples per window; legal range 2..12.
- CLK_DIV, 4, clk cycles per sample strobe; legal range 1..255.
- SETTLE_SMP, 2, samples discarded after start, before accumulation begins; legal range 0..15.

Ports:
- clk  in  1  system clock, single domain.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a measurement. Ignored unless the FSM is in IDLE.
- cont  in  1  1 = re-arm automatically after each window. Sampled at start and at every window end.
- ota_in  in  1  asynchronous comparator output.
- result  out  WIN_LOG2+1  ones count for the window, 0..2^WIN_LOG2.
- result_valid  out  1  result holds a valid window.
- result_ready  in  1  consumer accepts result.
- busy  out  1  FSM is not in IDLE.
- overrun  out  1  sticky; a window completed while result_valid was still high.
- clr_ovr  in  1  one-cycle pulse; clears overrun.

Behaviour:
- Reset: all state registers cleared in the cycle rst is high. Outputs are result=0, result_valid=0, busy=0, overrun=0, FSM=IDLE, prescaler=0, synchroniser flops=0.
- Synchroniser: 2 flops on ota_in. The synchronised bit is s_bit.
- Prescaler: counts 0..CLK_DIV-1 while busy. The strobe fires when the count is CLK_DIV-1, then the count wraps to 0. CLK_DIV=1 gives a strobe every cycle. Prescaler is held at 0 in IDLE.
- FSM states: IDLE, SETTLE, ACCUM, DONE.
  - IDLE: on start, go to SETTLE if SETTLE_SMP>0, else ACCUM. Clear sample counter and accumulator. Latch cont.
  - SETTLE: count strobes. After SETTLE_SMP strobes, go to ACCUM. s_bit is ignored.
  - ACCUM: on each strobe, accumulator += s_bit and sample counter += 1. When the sample counter reaches 2^WIN_LOG2, go to DONE in the same cycle the last strobe is taken.
  - DONE: lasts exactly one cycle.
    - If result_valid=0, or result_ready=1 in this cycle: load result with the accumulator and set result_valid=1.
    - Otherwise: set overrun=1 and keep the old result. The new window is dropped.
    - Next state is ACCUM with accumulator and counter cleared if the latched cont=1 (no re-settle), else IDLE.
- Accumulator width is WIN_LOG2+1, so the all-ones window gives exactly 2^WIN_LOG2 with no wrap. The sample counter is the same width.
- Handshake:
  - result_valid falls the cycle after valid && ready. result is stable while valid=1 and ready=0.
  - If DONE coincides with valid && ready, the new result loads and valid stays 1.
- Latency: first result_valid rises (SETTLE_SMP + 2^WIN_LOG2)*CLK_DIV + 1 cycles after the start cycle. This is measured from the start cycle to valid, assuming start is taken in IDLE.
- Continuous mode: consecutive windows are back-to-back with no lost strobes. Deasserting cont stops the block at the end of the current window.
- start while busy: ignored.
- rst mid-window: accumulation is aborted and there is no partial result.
- clr_ovr in the same cycle as a new overrun event: set wins.
- busy=0 only in IDLE.

Optional Feature:
- Macro: OTA_DEGLITCH_EN.
- Defined:
  - A 3-sample majority filter is placed on s_bit, clocked on the strobe. The accumulator adds the majority of the last 3 strobed samples.
  - The filter history is cleared to 0 on entry from IDLE.
  - SETTLE_SMP is internally raised to a minimum of 2 so the history is primed.
  - Latency grows accordingly.
- Undefined: raw s_bit is accumulated. SETTLE_SMP is used as given, and there is no extra logic.

Test Plan:
- ota_in=1 constant, WIN_LOG2=4, CLK_DIV=1, SETTLE_SMP=2, start pulse -> result=16, result_valid rises 19 cycles after start, busy low after.
- ota_in toggled every strobe (50% duty), WIN_LOG2=8, CLK_DIV=4 -> result=128 exactly.
- cont=1, result_ready held low, two windows complete -> first result held, overrun=1 after second DONE. clr_ovr pulse -> overrun=0.
- cont=1, result_ready=1 always, ota_in=0 -> result=0 each window, valid re-pulses every 2^WIN_LOG2*CLK_DIV cycles, no gap. Deassert cont -> block returns to IDLE after the current window.
- rst asserted halfway through ACCUM -> next cycle result=0, valid=0, busy=0. A subsequent start gives a full, correct window.
- With OTA_DEGLITCH_EN, ota_in=1 with a single-strobe 0 glitch every 8 samples, WIN_LOG2=4 -> result=16. Without the macro -> result=14.

Source files
------------

// File: rtl/ota_bitstream_decimator.sv
// ota_bitstream_decimator
// Synchronises the asynchronous comparator pin, samples it on a prescaled
// strobe and counts ones over 2^WIN_LOG2 samples. Each window count is
// presented on result/result_valid.
// Optional build macro: OTA_DEGLITCH_EN (3-sample majority filter on the
// strobed bit, minimum of two settle samples to prime its history).
//
// Handshake: result_valid/result form a valid/ready pair. A transfer happens
// on a clock edge where result_valid && result_ready. result is held stable
// while result_valid=1 and result_ready=0. A window completing while an
// untaken result is pending is dropped and flags the sticky overrun.
module ota_bitstream_decimator #(
  parameter int WIN_LOG2   = 8,
  parameter int CLK_DIV    = 4,
  parameter int SETTLE_SMP = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                cont,
  input  logic                ota_in,
  output logic [WIN_LOG2:0]   result,
  output logic                result_valid,
  input  logic                result_ready,
  output logic                busy,
  output logic                overrun,
  input  logic                clr_ovr
);

  localparam int CW = WIN_LOG2 + 1;
`ifdef OTA_DEGLITCH_EN
  localparam int SETTLE_EFF = (SETTLE_SMP < 2) ? 2 : SETTLE_SMP;
`else
  localparam int SETTLE_EFF = SETTLE_SMP;
`endif
  localparam logic [7:0]    DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [3:0]    SET_LAST = 4'((SETTLE_EFF == 0) ? 0 : SETTLE_EFF - 1);
  localparam logic [CW-1:0] WIN_LAST = CW'((1 << WIN_LOG2) - 1);

  typedef enum logic [1:0] {IDLE, SETTLE, ACCUM, DONE} state_t;

  state_t        state_q, state_d;
  logic          sync1_q, sync2_q;
  logic [7:0]    div_q, div_d;
  logic [3:0]    settle_q, settle_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [CW-1:0] acc_q, acc_d;
  logic          cont_q, cont_d;
  logic [CW-1:0] result_q, result_d;
  logic          valid_q, valid_d;
  logic          ovr_q, ovr_d;
  logic          strobe;
  logic          smp;
  logic [CW-1:0] smp_ext;
`ifdef OTA_DEGLITCH_EN
  logic [1:0]    hist_q, hist_d;
`endif

  // Prescaler: free-runs 0..CLK_DIV-1 while busy, parked at 0 in IDLE
  always_comb begin
    busy   = (state_q != IDLE);
    strobe = busy && (div_q == DIV_LAST);
    if (!busy || strobe) div_d = 8'd0;
    else                 div_d = div_q + 8'd1;
  end

  // Sample bit fed to the accumulator (raw or majority-filtered)
  always_comb begin
`ifdef OTA_DEGLITCH_EN
    smp = (hist_q[1] & hist_q[0]) | (hist_q[1] & sync2_q) | (hist_q[0] & sync2_q);
    if (state_q == IDLE) hist_d = 2'b00;
    else if (strobe)     hist_d = {hist_q[0], sync2_q};
    else                 hist_d = hist_q;
`else
    smp = sync2_q;
`endif
    smp_ext = {{(CW-1){1'b0}}, smp};
  end

  // Measurement FSM, accumulator, result register and overrun flag
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    cont_d   = cont_q;
    result_d = result_q;
    valid_d  = valid_q;
    ovr_d    = ovr_q;
    if (clr_ovr)                 ovr_d   = 1'b0;
    if (valid_q && result_ready) valid_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          cnt_d    = '0;
          acc_d    = '0;
          settle_d = 4'd0;
          cont_d   = cont;
          state_d  = (SETTLE_EFF > 0) ? SETTLE : ACCUM;
        end
      end
      SETTLE: begin
        if (strobe) begin
          if (settle_q == SET_LAST) state_d  = ACCUM;
          else                      settle_d = settle_q + 4'd1;
        end
      end
      ACCUM: begin
        if (strobe) begin
          acc_d = acc_q + smp_ext;
          cnt_d = cnt_q + CW'(1);
          if (cnt_q == WIN_LAST) begin
            state_d = DONE;
            cont_d  = cont;
          end
        end
      end
      DONE: begin
        if (!valid_q || result_ready) begin
          result_d = acc_q;
          valid_d  = 1'b1;
        end else begin
          ovr_d = 1'b1;
        end
        if (cont_q) begin
          // Back-to-back window: a strobe landing in this cycle is the
          // first sample of the next window so no strobe is lost.
          state_d = ACCUM;
          acc_d   = strobe ? smp_ext : '0;
          cnt_d   = strobe ? CW'(1) : '0;
        end else begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers with synchronous active-high reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      div_q    <= 8'd0;
      settle_q <= 4'd0;
      cnt_q    <= '0;
      acc_q    <= '0;
      cont_q   <= 1'b0;
      result_q <= '0;
      valid_q  <= 1'b0;
      ovr_q    <= 1'b0;
`ifdef OTA_DEGLITCH_EN
      hist_q   <= 2'b00;
`endif
    end else begin
      state_q  <= state_d;
      sync1_q  <= ota_in;
      sync2_q  <= sync1_q;
      div_q    <= div_d;
      settle_q <= settle_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      cont_q   <= cont_d;
      result_q <= result_d;
      valid_q  <= valid_d;
      ovr_q    <= ovr_d;
`ifdef OTA_DEGLITCH_EN
      hist_q   <= hist_d;
`endif
    end
  end

  assign result       = result_q;
  assign result_valid = valid_q;
  assign overrun      = ovr_q;

endmodule

// File: tb/tb_ota_bitstream_decimator.sv
// Bench for ota_bitstream_decimator: two instances (small fast window and
// the default-sized window) driven with directed patterns; results are
// checked through expected queues popped by per-instance monitors.
module tb_ota_bitstream_decimator;

  localparam int AW = 4, AD = 1, AS = 2;
  localparam int BW = 8, BD = 4, BS = 2;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst;

  logic          a_start, a_cont, a_ota, a_ready, a_clr;
  logic [AW:0]   a_result;
  logic          a_valid, a_busy, a_ovr;
  logic          b_start, b_cont, b_ota, b_ready, b_clr;
  logic [BW:0]   b_result;
  logic          b_valid, b_busy, b_ovr;

  int vectors = 0;
  int miscompares = 0;
  logic [AW:0] exp_a_q[$];
  logic [BW:0] exp_b_q[$];

  ota_bitstream_decimator #(.WIN_LOG2(AW), .CLK_DIV(AD), .SETTLE_SMP(AS)) dut_a (
    .clk(clk), .rst(rst), .start(a_start), .cont(a_cont), .ota_in(a_ota),
    .result(a_result), .result_valid(a_valid), .result_ready(a_ready),
    .busy(a_busy), .overrun(a_ovr), .clr_ovr(a_clr));

  ota_bitstream_decimator #(.WIN_LOG2(BW), .CLK_DIV(BD), .SETTLE_SMP(BS)) dut_b (
    .clk(clk), .rst(rst), .start(b_start), .cont(b_cont), .ota_in(b_ota),
    .result(b_result), .result_valid(b_valid), .result_ready(b_ready),
    .busy(b_busy), .overrun(b_ovr), .clr_ovr(b_clr));

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // pin pattern drivers: constant level, or a pattern clocked off negedge
  int   a_mode = 0, a_cyc = 0;
  logic a_level = 1'b0;
  always @(negedge clk) begin
    a_cyc++;
    if (a_mode == 1) a_ota = ((a_cyc % 8) == 3) ? 1'b0 : 1'b1;
    else             a_ota = a_level;
  end

  int   b_mode = 0, b_cyc = 0;
  logic b_level = 1'b0, b_tog = 1'b0;
  always @(negedge clk) begin
    b_cyc++;
    if (b_mode == 1) begin
      if ((b_cyc % BD) == 0) b_tog = ~b_tog;
      b_ota = b_tog;
    end else begin
      b_ota = b_level;
    end
  end

  // scoreboard monitors: one pop per accepted transfer
  always @(negedge clk) begin
    logic [AW:0] e;
    if (!rst && a_valid && a_ready) begin
      if (exp_a_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL a_unexpected_result: got %0d expected none", a_result);
      end else begin
        e = exp_a_q.pop_front();
        check("a_result", a_result, e);
      end
    end
  end

  always @(negedge clk) begin
    logic [BW:0] e;
    if (!rst && b_valid && b_ready) begin
      if (exp_b_q.size() == 0) begin
        vectors++; miscompares++;
        $display("FAIL b_unexpected_result: got %0d expected none", b_result);
      end else begin
        e = exp_b_q.pop_front();
        check("b_result", b_result, e);
      end
    end
  end

  // driver tasks
  task automatic cycles(input int n);
    repeat (n) @(negedge clk);
  endtask

  // pulse start on A and count cycles from the start edge to result_valid
  task automatic a_start_and_time(output int lat);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    lat = 0;
    while (!a_valid && lat < 2000) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic b_start_and_time(output int lat);
    @(negedge clk); b_start = 1'b1;
    @(negedge clk); b_start = 1'b0;
    lat = 0;
    while (!b_valid && lat < 5000) begin
      @(negedge clk); lat++;
    end
  endtask

  task automatic a_wait_idle();
    int k = 0;
    while (a_busy && k < 200) begin
      @(negedge clk); k++;
    end
  endtask

  initial begin
    int lat, gap;
    rst = 1'b1;
    a_start = 0; a_cont = 0; a_ready = 1; a_clr = 0;
    b_start = 0; b_cont = 0; b_ready = 1; b_clr = 0;
    cycles(3);
    check("a_rst_result", a_result, 0);
    check("a_rst_valid",  a_valid, 0);
    check("a_rst_busy",   a_busy, 0);
    check("a_rst_ovr",    a_ovr, 0);
    check("b_rst_result", b_result, 0);
    check("b_rst_valid",  b_valid, 0);
    check("b_rst_busy",   b_busy, 0);
    check("b_rst_ovr",    b_ovr, 0);
    rst = 1'b0;

    // all-ones single window, latency (2+16)*1+1
    a_level = 1'b1;
    cycles(4);
    exp_a_q.push_back(5'd16);
    a_start_and_time(lat);
    check("a_latency_ones", lat, 19);
    cycles(2);
    check("a_busy_after_single", a_busy, 0);
    check("a_valid_after_accept", a_valid, 0);

    // overrun: continuous, consumer stalled, second window dropped
    a_ready = 1'b0; a_cont = 1'b1;
    exp_a_q.push_back(5'd16);
    a_start_and_time(lat);
    check("a_latency_ovr", lat, 19);
    a_cont = 1'b0; a_level = 1'b0;
    a_wait_idle();
    check("a_idle_after_ovr", a_busy, 0);
    check("a_ovr_set", a_ovr, 1);
    check("a_held_valid", a_valid, 1);
    check("a_held_result", a_result, 16);
    @(negedge clk); a_clr = 1'b1;
    @(negedge clk); a_clr = 1'b0;
    check("a_ovr_cleared", a_ovr, 0);
    a_ready = 1'b1;
    cycles(3);
    check("a_valid_drop", a_valid, 0);

    // reset halfway through ACCUM aborts the window
    a_level = 1'b1;
    cycles(4);
    @(negedge clk); a_start = 1'b1;
    @(negedge clk); a_start = 1'b0;
    cycles(10);
    rst = 1'b1;
    @(negedge clk);
    check("a_midrst_result", a_result, 0);
    check("a_midrst_valid",  a_valid, 0);
    check("a_midrst_busy",   a_busy, 0);
    rst = 1'b0;
    exp_a_q.push_back(5'd16);
    a_start_and_time(lat);
    check("a_latency_after_rst", lat, 19);
    cycles(2);

    // continuous zeros: back-to-back windows, start while busy ignored
    a_level = 1'b0; a_cont = 1'b1;
    cycles(4);
    repeat (3) exp_a_q.push_back(5'd0);
    a_start_and_time(lat);
    check("a_latency_cont", lat, 19);
    gap = 0;
    do begin
      @(negedge clk); gap++;
      if (gap == 5) a_start = 1'b1;
      if (gap == 6) a_start = 1'b0;
    end while (!a_valid && gap < 100);
    check("a_cont_gap1", gap, 16);
    a_cont = 1'b0;
    gap = 0;
    do begin
      @(negedge clk); gap++;
    end while (!a_valid && gap < 100);
    check("a_cont_gap2", gap, 16);
    a_wait_idle();
    check("a_cont_stopped", a_busy, 0);
    cycles(40);

    // glitch pattern: one zero every 8 samples
    a_mode = 1;
    cycles(10);
`ifdef OTA_DEGLITCH_EN
    exp_a_q.push_back(5'd16);
`else
    exp_a_q.push_back(5'd14);
`endif
    a_start_and_time(lat);
    check("a_latency_glitch", lat, 19);
    cycles(3);
    a_mode = 0;

    // 50% density on the default-sized window, latency (2+256)*4+1
    b_mode = 1;
    cycles(8);
    exp_b_q.push_back(9'd128);
    b_start_and_time(lat);
    check("b_latency_half", lat, 1033);
    cycles(4);
    check("b_busy_after", b_busy, 0);
    check("b_ovr_none", b_ovr, 0);
    b_mode = 0;

    cycles(5);
    check("a_queue_drained", exp_a_q.size(), 0);
    check("b_queue_drained", exp_b_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
